// File: rtl/blind_sequencer_pkg.sv
// Shared encodings for the blind motor sequencer: motor commands, position
// codes and controller states.
package blind_sequencer_pkg;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;

    localparam logic [1:0] POS_UNKNOWN = 2'b00;
    localparam logic [1:0] POS_OPEN    = 2'b01;
    localparam logic [1:0] POS_CLOSED  = 2'b10;
    localparam logic [1:0] POS_BETWEEN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD,
        ST_UP,
        ST_DOWN,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/blind_req_arb.sv
// Priority resolution of manual and automatic requests for one blind:
// man_stop, then manual direction, then automatic direction.
module blind_req_arb (
    input  logic man_up,
    input  logic man_down,
    input  logic man_stop,
    input  logic auto_en,
    input  logic auto_up,
    input  logic auto_down,
    output logic stop,
    output logic dir_valid,
    output logic dir
);

    logic man_any;
    logic man_dir_valid;
    logic auto_dir_valid;

    // Up and down together from one source cancel; any manual activity mutes auto.
    assign man_any        = man_up | man_down | man_stop;
    assign man_dir_valid  = man_up ^ man_down;
    assign auto_dir_valid = auto_en & (auto_up ^ auto_down) & ~man_any;

    assign stop      = man_stop;
    assign dir_valid = ~man_stop & (man_dir_valid | auto_dir_valid);
    // dir: 0 = up, 1 = down
    assign dir       = man_dir_valid ? man_down : auto_down;

endmodule

// File: rtl/blind_sequencer.sv
// Motor sequencer for one blind: request arbitration, dead-time before every
// start/reversal, travel timeout and limit-switch sanity, with registered outputs.
module blind_sequencer
    import blind_sequencer_pkg::*;
#(
    parameter int unsigned DEADTIME_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       man_up,
    input  logic       man_down,
    input  logic       man_stop,
    input  logic       auto_en,
    input  logic       auto_up,
    input  logic       auto_down,
    input  logic       lim_up,
    input  logic       lim_down,
    output logic [1:0] cmd,
    output logic       moving,
    output logic       fault,
    output logic [1:0] pos
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic req_stop;
    logic req_valid;
    logic req_dir;

    blind_req_arb u_arb (
        .man_up    (man_up),
        .man_down  (man_down),
        .man_stop  (man_stop),
        .auto_en   (auto_en),
        .auto_up   (auto_up),
        .auto_down (auto_down),
        .stop      (req_stop),
        .dir_valid (req_valid),
        .dir       (req_dir)
    );

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       tgt_q, tgt_n;
    logic [1:0]       pos_q, pos_n;
    logic [1:0]       cmd_q, cmd_n;
    logic             moving_q, moving_n;
    logic             fault_q, fault_n;

    logic       both_lim;
    logic [1:0] req_cmd;
    logic       accept;
    logic [1:0] run_cmd;
    logic       run_lim;

    assign both_lim = lim_up & lim_down;
    assign req_cmd  = req_dir ? CMD_DOWN : CMD_UP;
    // A request toward a limit that is already active is dropped.
    assign accept   = req_valid & ~(req_dir ? lim_down : lim_up);
    assign run_cmd  = (state_q == ST_UP) ? CMD_UP : CMD_DOWN;
    assign run_lim  = (state_q == ST_UP) ? lim_up : lim_down;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tgt_q    <= CMD_STOP;
            pos_q    <= POS_UNKNOWN;
            cmd_q    <= CMD_STOP;
            moving_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            tgt_q    <= tgt_n;
            pos_q    <= pos_n;
            cmd_q    <= cmd_n;
            moving_q <= moving_n;
            fault_q  <= fault_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        tgt_n   = tgt_q;
        pos_n   = pos_q;

        case (state_q)
            ST_IDLE: begin
                if (lim_up)
                    pos_n = POS_OPEN;
                else if (lim_down)
                    pos_n = POS_CLOSED;
                if (accept) begin
                    state_n = ST_DEAD;
                    tgt_n   = req_cmd;
                    cnt_n   = DEAD_LOAD;
                    pos_n   = POS_BETWEEN;
                end
            end
            ST_DEAD: begin
                if (req_stop) begin
                    state_n = ST_IDLE;
                    tgt_n   = CMD_STOP;
                    cnt_n   = '0;
                end else if (accept && req_cmd != tgt_q) begin
                    tgt_n = req_cmd;
                    cnt_n = DEAD_LOAD;
                end else if (cnt_q == '0) begin
                    state_n = (tgt_q == CMD_UP) ? ST_UP : ST_DOWN;
                    tgt_n   = CMD_STOP;
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            ST_UP, ST_DOWN: begin
                if (run_lim) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    pos_n   = (state_q == ST_UP) ? POS_OPEN : POS_CLOSED;
                end else if (req_stop) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    pos_n   = POS_BETWEEN;
                end else if (cnt_q == TO_LAST) begin
                    state_n = ST_FAULT;
                    cnt_n   = '0;
                    pos_n   = POS_UNKNOWN;
                end else if (accept && req_cmd != run_cmd) begin
                    state_n = ST_DEAD;
                    tgt_n   = req_cmd;
                    cnt_n   = DEAD_LOAD;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            ST_FAULT: begin
                if (req_stop && !both_lim) begin
                    state_n = ST_IDLE;
                    if (lim_up)
                        pos_n = POS_OPEN;
                    else if (lim_down)
                        pos_n = POS_CLOSED;
                    else
                        pos_n = POS_UNKNOWN;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                tgt_n   = CMD_STOP;
                pos_n   = POS_UNKNOWN;
            end
        endcase

        // Both limits at once means broken wiring; overrides everything above.
        if (state_q != ST_FAULT && both_lim) begin
            state_n = ST_FAULT;
            cnt_n   = '0;
            tgt_n   = CMD_STOP;
            pos_n   = POS_UNKNOWN;
        end

        cmd_n    = (state_n == ST_UP)   ? CMD_UP :
                   (state_n == ST_DOWN) ? CMD_DOWN : CMD_STOP;
        moving_n = (state_n == ST_DEAD) || (state_n == ST_UP) || (state_n == ST_DOWN);
        fault_n  = (state_n == ST_FAULT);
    end

    assign cmd    = cmd_q;
    assign moving = moving_q;
    assign fault  = fault_q;
    assign pos    = pos_q;

endmodule

// File: tb/tb_blind_sequencer.sv
// Self-checking bench for blind_sequencer with DEADTIME_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_blind_sequencer;
    import blind_sequencer_pkg::*;

    localparam int unsigned DT = 4;
    localparam int unsigned TO = 20;

    localparam logic [7:0] MU = 8'h80;
    localparam logic [7:0] MD = 8'h40;
    localparam logic [7:0] MS = 8'h20;
    localparam logic [7:0] AE = 8'h10;
    localparam logic [7:0] AU = 8'h08;
    localparam logic [7:0] AD = 8'h04;
    localparam logic [7:0] LU = 8'h02;
    localparam logic [7:0] LD = 8'h01;
    localparam logic [7:0] NONE = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       man_up = 1'b0, man_down = 1'b0, man_stop = 1'b0;
    logic       auto_en = 1'b0, auto_up = 1'b0, auto_down = 1'b0;
    logic       lim_up = 1'b0, lim_down = 1'b0;
    logic [1:0] cmd;
    logic       moving;
    logic       fault;
    logic [1:0] pos;

    always #5 clk = ~clk;

    blind_sequencer #(
        .DEADTIME_CYCLES (DT),
        .TIMEOUT_CYCLES  (TO),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .man_up    (man_up),
        .man_down  (man_down),
        .man_stop  (man_stop),
        .auto_en   (auto_en),
        .auto_up   (auto_up),
        .auto_down (auto_down),
        .lim_up    (lim_up),
        .lim_down  (lim_down),
        .cmd       (cmd),
        .moving    (moving),
        .fault     (fault),
        .pos       (pos)
    );

    typedef struct packed {
        logic [7:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Expected output bundles {cmd, moving, fault, pos}
    function automatic logic [5:0] idle(input logic [1:0] p);
        return {CMD_STOP, 1'b0, 1'b0, p};
    endfunction
    localparam logic [5:0] DEAD = {2'b00, 1'b1, 1'b0, 2'b11};
    localparam logic [5:0] UPX  = {2'b01, 1'b1, 1'b0, 2'b11};
    localparam logic [5:0] DNX  = {2'b10, 1'b1, 1'b0, 2'b11};
    localparam logic [5:0] FLT  = {2'b00, 1'b0, 1'b1, 2'b00};

    function automatic logic [5:0] outs();
        return {cmd, moving, fault, pos};
    endfunction

    task automatic add(input int n, input logic [7:0] in, input logic [5:0] e);
        for (int i = 0; i < n; i++) vecs.push_back('{in: in, exp: e});
    endtask

    task automatic drive(input logic [7:0] in);
        {man_up, man_down, man_stop, auto_en, auto_up, auto_down, lim_up, lim_down} = in;
    endtask

    task automatic chk(input string name, input int idx, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got cmd=%b moving=%b fault=%b pos=%b, want cmd=%b moving=%b fault=%b pos=%b",
                     name, idx, got[5:4], got[3], got[2], got[1:0], want[5:4], want[3], want[2], want[1:0]);
        end
    endtask

    task automatic apply(input string name, input int idx, input logic [7:0] in, input logic [5:0] want);
        logic [5:0] e;
        drive(in);
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s step %0d: scoreboard empty", name, idx);
        end else begin
            e = exp_q.pop_front();
            chk(name, idx, outs(), e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Open from unknown, then limit-ignore with lim_up high
        add(1, NONE, idle(2'b00));
        add(1, MU, DEAD);  add(3, NONE, DEAD);  add(2, NONE, UPX);
        add(1, LU, idle(2'b01));
        add(1, LU | MU, idle(2'b01));
        // Close, then reversals from DOWN and from UP
        add(1, MD, DEAD);  add(3, NONE, DEAD);  add(2, NONE, DNX);
        add(1, MU, DEAD);  add(3, NONE, DEAD);  add(2, NONE, UPX);
        add(1, MD, DEAD);  add(3, NONE, DEAD);  add(1, NONE, DNX);
        add(2, LD, idle(2'b10));
        // Arbitration: manual beats auto, auto gated by auto_en and conflicts
        add(1, AE | MU | AD, DEAD);  add(3, NONE, DEAD);  add(1, NONE, UPX);
        add(1, MS, idle(2'b11));
        add(1, AU, idle(2'b11));
        add(1, AE | AU | AD, idle(2'b11));
        add(1, AE | AU, DEAD);  add(3, NONE, DEAD);  add(1, NONE, UPX);
        add(1, AE | AD | MU, UPX);
        add(1, MS, idle(2'b11));
        // Both limits during DOWN, then fault clearing
        add(1, MD, DEAD);  add(3, NONE, DEAD);  add(1, NONE, DNX);
        add(1, LU | LD, FLT);
        add(1, LU | LD | MS, FLT);
        add(1, LD | MS, idle(2'b10));
        // Stop in DEAD; opposite request in DEAD reloads the dead-time
        add(1, MU, DEAD);
        add(2, MS, idle(2'b11));
        add(1, MU, DEAD);  add(1, NONE, DEAD);  add(1, MD, DEAD);
        add(3, NONE, DEAD);  add(1, NONE, DNX);
        add(1, MS, idle(2'b11));

        drive(NONE);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 0, outs(), idle(2'b00));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            apply("table", i, vecs[i].in, vecs[i].exp);

        // Travel timeout: exactly TO cycles of DOWN, then FAULT
        apply("timeout_start", 0, MD, DEAD);
        for (int i = 1; i < DT; i++) apply("timeout_dead", i, NONE, DEAD);
        for (int i = 0; i < TO; i++) apply("timeout_down", i, NONE, DNX);
        apply("timeout_fault", 0, NONE, FLT);
        apply("fault_ignores_up", 0, MU, FLT);
        apply("fault_clear", 0, MS, idle(2'b00));

        // Asynchronous reset while moving up
        apply("async_prep", 0, MU, DEAD);
        for (int i = 1; i < DT; i++) apply("async_prep", i, NONE, DEAD);
        apply("async_prep_up", 0, NONE, UPX);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", 0, outs(), idle(2'b00));
        @(posedge clk);
        #1;
        chk("async_reset_hold", 0, outs(), idle(2'b00));
        @(negedge clk);
        reset = 1'b0;
        apply("after_reset", 0, NONE, idle(2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blind_sequencer.md
Name: blind_sequencer

Overview:
- Controller that sequences the motor block for one motorised blind/shutter and drives its 2-bit cmd.
- Arbitrates between two requesters: manual panel buttons and an automatic source (light/schedule logic).
- Enforces a stopped dead-time before every start and reversal, a travel timeout, and limit-switch sanity.
- Reports position and fault status to the house controller.

Parameters:
- DEADTIME_CYCLES, 50000: cycles with cmd=00 before any motor start or reversal (min 1).
- TIMEOUT_CYCLES, 500000000: maximum cycles in a move before a fault is declared (min 2).
- CNT_W, 32: width of the shared dead-time/timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- man_up  in  1  manual open request, 1-cycle pulse
- man_down  in  1  manual close request, 1-cycle pulse
- man_stop  in  1  manual stop/fault-clear, 1-cycle pulse
- auto_en  in  1  enables the automatic requester
- auto_up  in  1  automatic open request, 1-cycle pulse
- auto_down  in  1  automatic close request, 1-cycle pulse
- lim_up  in  1  upper limit status from motor block (TopeA_S)
- lim_down  in  1  lower limit status from motor block (TopeB_S)
- cmd  out  2  to motor block: 00 stop, 01 up, 10 down; 11 never driven
- moving  out  1  high in DEAD, UP or DOWN
- fault  out  1  high in FAULT
- pos  out  2  00 unknown, 01 open, 10 closed, 11 between

Behaviour:
- Reset (async): state=IDLE, cnt=0, cmd=00, moving=0, fault=0, pos=00, pending direction=none. All outputs are registered.
- States: IDLE, DEAD, UP, DOWN, FAULT. cmd=01 only in UP, cmd=10 only in DOWN, otherwise 00.
- Request resolution per cycle, highest priority first:
  - man_stop
  - manual direction
  - auto direction, only when auto_en=1
- A source asserting up and down together issues no direction request. Auto requests are ignored whenever any manual input is high in the same cycle.
- Accepted direction request in IDLE, or an opposite-direction request in UP/DOWN:
  - go to DEAD, latch target, cnt=DEADTIME_CYCLES-1, cmd=00 on the next edge.
  - Exception: request ignored if the target limit is already active (up with lim_up=1, or down with lim_down=1).
- Same-direction request in UP/DOWN: ignored; the timeout is not restarted.
- DEAD: cnt decrements each cycle. At cnt==0, go to UP/DOWN with cnt=0.
  - Latency: a request sampled at edge t gives cmd=01/10 at edge t+1+DEADTIME_CYCLES.
  - A new opposite request in DEAD overwrites the target and reloads cnt.
  - man_stop in DEAD returns to IDLE.
- UP: cnt increments.
  - lim_up=1: go to IDLE, pos=01.
  - cnt==TIMEOUT_CYCLES-1 with lim_up=0: go to FAULT.
  - Same rules for DOWN with lim_down and pos=10.
  - Limit check has priority over timeout on the same cycle.
- man_stop in UP/DOWN: go to IDLE on the next edge, cmd=00, pos=11.
- lim_up=1 and lim_down=1 together, in any non-FAULT state: go to FAULT next edge, cmd=00. This overrides all requests.
- FAULT: cmd=00, fault=1, pos=00. All requests are ignored except man_stop.
  - man_stop with both limits low: go to IDLE, fault=0.
  - man_stop with a single limit high: go to IDLE with pos set from that limit.
  - man_stop with both limits high: stay in FAULT.
- pos in IDLE tracks the limits each cycle:
  - lim_up → 01
  - lim_down → 10
  - neither → keep the last value (00 if unknown since reset/fault, else 11 after a stop).
- Entering DEAD/UP/DOWN sets pos=11.
- Reset mid-move: cmd=00 immediately (asynchronous); no memory of the previous move.

Decomposition:
- Shared package holds:
  - cmd encodings CMD_STOP=2'b00, CMD_UP=2'b01, CMD_DOWN=2'b10 (shared with the motor block and the house controller);
  - pos encodings;
  - state enum.
- One sub-module: blind_req_arb. It is combinational priority resolution of man_*/auto_* into {stop, dir_valid, dir} and is reusable per blind.
- FSM and the single counter stay in blind_sequencer.

Test Plan (DEADTIME_CYCLES=4, TIMEOUT_CYCLES=20):
- Open from unknown: reset, pulse man_up at edge 10.
  - Required: cmd=00 at edges 11–14, cmd=01 at edge 15.
  - Raise lim_up at edge 18 → cmd=00 and pos=01 at edge 19, moving=0.
- Reversal: while UP, pulse man_down.
  - Required: cmd=00 for exactly 4 cycles, then 10.
  - Raise lim_down → pos=10.
- Timeout: man_down with no limit ever asserted.
  - Required: cmd=10 for exactly 20 cycles, then fault=1, cmd=00, pos=00.
  - man_up is ignored; man_stop → IDLE, fault=0.
- Arbitration: man_up and auto_down in the same cycle with auto_en=1.
  - Required: target up, cmd=01 after dead-time.
  - auto_up with auto_en=0 → no response; auto_up and auto_down together → no response.
- Limit sanity/ignore:
  - man_up with lim_up=1 → stays IDLE, cmd=00.
  - lim_up=1 and lim_down=1 during DOWN → FAULT next edge.
- Async reset: assert reset mid-UP, between clock edges.
  - Required: cmd=00, moving=0, pos=00 before the next edge.
